// File: rtl/pair_deser.sv
// Packs LSB-first 2-bit pairs into WORD_W-bit words behind a single output holding register.
// Latency: out_valid rises the cycle after the edge that accepts the last pair of a word.
// Backpressure: only the completing pair stalls (in_ready=0) while a held word is not taken.
// Optional parity output enabled by defining PAIR_DESER_PARITY_EN.
module pair_deser #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_par
);

    localparam int NP = WORD_W / 2;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NP - 1);

    logic [WORD_W-3:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic accept;
    logic deliver;
    logic last_pair;

    // Handshake decode; only the completing pair can be held off by a stalled word
    always_comb begin
        last_pair = (cnt_q == LAST);
        in_ready  = !last_pair || !out_valid_q || out_ready;
        accept    = in_valid && in_ready && !flush;
        deliver   = out_valid_q && out_ready;
    end

    // Next-state for the accumulator, pair counter and output holding register
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (deliver) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            if (last_pair) begin
                // acc keeps stale bits; every slot is rewritten before the next completion
                out_data_d  = {in_data, acc_q};
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                for (int i = 0; i < NP - 1; i++) begin
                    if (cnt_q == CW'(i)) begin
                        acc_d[2*i +: 2] = in_data;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef PAIR_DESER_PARITY_EN
    logic out_par_q, out_par_d;

    // Parity is captured alongside the word so it stays aligned while the word is held
    always_comb begin
        out_par_d = out_par_q;
        if (!flush && accept && last_pair) begin
            out_par_d = ^{in_data, acc_q};
        end
    end

    // Parity register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`else
    assign out_par = 1'b0;
`endif

endmodule
